// File: rtl/wb_pkg.sv
// Shared codes for the writeback select stage: source selects, load kinds, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

  localparam logic [2:0] SEL_LINK = 3'b001;
  localparam logic [2:0] SEL_MEM  = 3'b010;
  localparam logic [2:0] SEL_CP0  = 3'b011;
  localparam logic [2:0] SEL_HI   = 3'b100;
  localparam logic [2:0] SEL_LO   = 3'b101;
  localparam logic [2:0] SEL_ALU  = 3'b110;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  // Everything about a stalled HI/LO read except the destination index.
  typedef struct packed {
    logic [2:0] sel;
    logic       wen;
  } hold_t;

  function automatic logic is_hilo(input logic [2:0] s);
    return (s == SEL_HI) || (s == SEL_LO);
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Little-endian sub-word load aligner and sign/zero extender.
// Latency: combinational.
// Backpressure: none.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] dm_out,
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] ld_d
);

  logic [7:0]  byte_d;
  logic [15:0] half_d;

  assign byte_d = dm_out[{addr_lo, 3'b000} +: 8];
  // Halves are always naturally aligned, so the low address bit is ignored.
  assign half_d = dm_out[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_d = dm_out;
    case (ld_type)
      LD_LB:   ld_d = {{(DATA_W-8){byte_d[7]}}, byte_d};
      LD_LBU:  ld_d = {{(DATA_W-8){1'b0}}, byte_d};
      LD_LH:   ld_d = {{(DATA_W-16){half_d[15]}}, half_d};
      LD_LHU:  ld_d = {{(DATA_W-16){1'b0}}, half_d};
      default: ld_d = dm_out;
    endcase
  end

endmodule

// File: rtl/wb_select_pipe.sv
// Writeback data select: muxes ALU/link/mem/CP0/HI/LO into a registered GPR write port.
// Latency: 1 cycle; HI/LO reads wait in WAIT until muldiv_busy drops (in_ready=0 there).
// Backpressure: in_ready low only while WAIT; WB_LOAD_EXT_EN enables sub-word load extension.
module wb_select_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int PC_LINK_OFS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        sel,
  input  logic              wen_in,
  input  logic [REG_AW-1:0] wr_num,
  input  logic [DATA_W-1:0] alu_r,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] dm_out,
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] cp0_d,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic              muldiv_busy,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_wnum,
  output logic [DATA_W-1:0] reg_din
);

  wb_state_t         state;
  hold_t             hold;
  logic [REG_AW-1:0] hold_wnum;

  logic              accept;
  logic [DATA_W-1:0] mem_d;
  logic [DATA_W-1:0] link_d;
  logic [DATA_W-1:0] src_d;
  logic [DATA_W-1:0] held_hilo_d;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready & ~flush;

`ifdef WB_LOAD_EXT_EN
  wb_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .dm_out  (dm_out),
    .ld_type (ld_type),
    .addr_lo (addr_lo),
    .ld_d    (mem_d)
  );
`else
  logic unused_ld;
  assign mem_d     = dm_out;
  assign unused_ld = ^{ld_type, addr_lo};
`endif

  // Link address wraps silently at 2^DATA_W.
  assign link_d = pc + DATA_W'(PC_LINK_OFS);

  always_comb begin
    src_d = '0;
    case (sel)
      SEL_ALU:  src_d = alu_r;
      SEL_LINK: src_d = link_d;
      SEL_MEM:  src_d = mem_d;
      SEL_CP0:  src_d = cp0_d;
      SEL_HI:   src_d = hi;
      SEL_LO:   src_d = lo;
      default:  src_d = '0;
    endcase
  end

  // A stalled read samples HI/LO live on the cycle busy drops, not at accept.
  assign held_hilo_d = (hold.sel == SEL_HI) ? hi : lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      hold_wnum <= '0;
      reg_we    <= 1'b0;
      reg_wnum  <= '0;
      reg_din   <= '0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_hilo(sel) && muldiv_busy) begin
              hold.sel  <= sel;
              hold.wen  <= wen_in;
              hold_wnum <= wr_num;
              state     <= WAIT;
            end else if (wen_in && (wr_num != '0)) begin
              reg_we   <= 1'b1;
              reg_wnum <= wr_num;
              reg_din  <= src_d;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (!muldiv_busy) begin
            if (hold.wen && (hold_wnum != '0)) begin
              reg_we   <= 1'b1;
              reg_wnum <= hold_wnum;
              reg_din  <= held_hilo_d;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_select_pipe.sv
// Randomized scoreboard bench for wb_select_pipe against a spec-level reference model.
module tb_wb_select_pipe;
  import wb_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int OFS = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    sel = '0;
  logic          wen_in = 1'b0;
  logic [AW-1:0] wr_num = '0;
  logic [DW-1:0] alu_r = '0, pc = '0, dm_out = '0, cp0_d = '0, hi = '0, lo = '0;
  logic [2:0]    ld_type = '0;
  logic [1:0]    addr_lo = '0;
  logic          muldiv_busy = 1'b0;
  logic          reg_we;
  logic [AW-1:0] reg_wnum;
  logic [DW-1:0] reg_din;

  wb_select_pipe #(.DATA_W(DW), .REG_AW(AW), .PC_LINK_OFS(OFS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .wen_in(wen_in), .wr_num(wr_num), .alu_r(alu_r), .pc(pc), .dm_out(dm_out),
    .ld_type(ld_type), .addr_lo(addr_lo), .cp0_d(cp0_d), .hi(hi), .lo(lo),
    .muldiv_busy(muldiv_busy), .reg_we(reg_we), .reg_wnum(reg_wnum), .reg_din(reg_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] wnum;
    logic [DW-1:0] din;
  } exp_t;
  exp_t q[$];

  // Sub-word loads modelled with shifts, masks and two's-complement arithmetic.
  function automatic logic [DW-1:0] mem_model(input logic [DW-1:0] d, input logic [2:0] ld,
                                              input logic [1:0] al);
    logic [DW-1:0] w;
    w = d;
`ifdef WB_LOAD_EXT_EN
    case (ld)
      3'd1, 3'd2: begin
        w = (d >> (8 * al)) & 32'hFF;
        if (ld == 3'd1 && w >= 32'd128) w = w - 32'd256;
      end
      3'd3, 3'd4: begin
        w = (d >> (16 * (al / 2))) & 32'hFFFF;
        if (ld == 3'd3 && w >= 32'd32768) w = w - 32'd65536;
      end
      default: w = d;
    endcase
`endif
    return w;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [2:0] s);
    case (s)
      3'b110:  return alu_r;
      3'b001:  return pc + 32'(OFS);
      3'b010:  return mem_model(dm_out, ld_type, addr_lo);
      3'b011:  return cp0_d;
      3'b100:  return hi;
      3'b101:  return lo;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] n, input logic [DW-1:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.wnum = n;
    e.din  = d;
    q.push_back(e);
  endtask

  // Monitor: every cycle either the due write appears exactly, or reg_we stays low.
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_write: wnum %0d din %0h due cycle %0d not seen", q[0].wnum,
                 q[0].din, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        checks++;
        if (reg_we !== 1'b1 || reg_wnum !== q[0].wnum || reg_din !== q[0].din) begin
          errors++;
          $display("FAIL write: got we=%b wnum=%0d din=%0h expected we=1 wnum=%0d din=%0h cyc %0d",
                   reg_we, reg_wnum, reg_din, q[0].wnum, q[0].din, cyc);
        end
        void'(q.pop_front());
      end else if (reg_we !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got we=%b wnum=%0d din=%0h expected we=0 cyc %0d",
                 reg_we, reg_wnum, reg_din, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    alu_r   = $urandom;
    pc      = $urandom;
    dm_out  = $urandom;
    cp0_d   = $urandom;
    hi      = $urandom;
    lo      = $urandom;
    ld_type = 3'($urandom_range(0, 7));
    addr_lo = 2'($urandom_range(0, 3));
  endtask

  // One-cycle request from IDLE; operands must already be set by the caller.
  task automatic issue(input logic [2:0] s, input logic w, input logic [AW-1:0] n,
                       input logic f, input logic b);
    sel = s; wen_in = w; wr_num = n; flush = f; muldiv_busy = b; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    if (!f && !(is_hilo(s) && b) && w && n != '0) push_exp(n, exp_data(s));
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // HI/LO read with busy high for nb cycles (accept cycle included), then a drop cycle.
  task automatic issue_wait(input logic [2:0] s, input logic w, input logic [AW-1:0] n,
                            input int nb, input logic fdrop);
    rnd_ops();
    issue(s, w, n, 1'b0, 1'b1);
    for (int i = 1; i < nb; i++) begin
      rnd_ops();
      in_valid = 1'($urandom_range(0, 1)); sel = 3'($urandom); wr_num = AW'($urandom);
      wen_in = 1'b1; muldiv_busy = 1'b1;
      chk("in_ready_wait", 64'(in_ready), 64'd0);
      tick();
    end
    rnd_ops();
    muldiv_busy = 1'b0; flush = fdrop;
    chk("in_ready_wait_drop", 64'(in_ready), 64'd0);
    if (!fdrop && w && n != '0) push_exp(n, (s == SEL_HI) ? hi : lo);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("in_ready_after_wait", 64'(in_ready), 64'd1);
  endtask

  task automatic idle_cycle();
    rnd_ops();
    in_valid = 1'b0;
    muldiv_busy = 1'($urandom_range(0, 1));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]    s;
    logic [AW-1:0] n;
    int            r;

    #12;
    chk("reset_we", 64'(reg_we), 64'd0);
    chk("reset_wnum", 64'(reg_wnum), 64'd0);
    chk("reset_din", 64'(reg_din), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Link wraps past 2^32.
    rnd_ops(); pc = 32'hFFFF_FFFC;
    issue(SEL_LINK, 1'b1, AW'(31), 1'b0, 1'b0);
    idle_cycle();

    // HI read stalled three cycles.
    issue_wait(SEL_HI, 1'b1, AW'(12), 3, 1'b0);
    idle_cycle();

    // Flush coincident with busy drop discards the held read.
    issue_wait(SEL_LO, 1'b1, AW'(13), 2, 1'b1);

    // r0 never written; then three back-to-back ALU writes.
    rnd_ops(); issue(SEL_ALU, 1'b1, AW'(0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rnd_ops(); issue(SEL_ALU, 1'b1, AW'(i + 1), 1'b0, 1'($urandom_range(0, 1)));
    end

    // Sub-word loads (plain word pass-through when the extender is absent).
    rnd_ops(); dm_out = 32'h80FF_7F01; ld_type = LD_LB; addr_lo = 2'd3;
    issue(SEL_MEM, 1'b1, AW'(4), 1'b0, 1'b0);
    rnd_ops(); dm_out = 32'h80FF_7F01; ld_type = LD_LHU; addr_lo = 2'd2;
    issue(SEL_MEM, 1'b1, AW'(5), 1'b0, 1'b0);
    idle_cycle();

    // Asynchronous reset while a HI/LO read is held.
    rnd_ops(); alu_r = 32'hA5A5_0001;
    issue(SEL_ALU, 1'b1, AW'(7), 1'b0, 1'b0);
    rnd_ops(); issue(SEL_LO, 1'b1, AW'(9), 1'b0, 1'b1);
    muldiv_busy = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("midwait_reset_we", 64'(reg_we), 64'd0);
    chk("midwait_reset_wnum", 64'(reg_wnum), 64'd0);
    chk("midwait_reset_din", 64'(reg_din), 64'd0);
    chk("midwait_reset_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    muldiv_busy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_ops(); in_valid = 1'b0; muldiv_busy = 1'b0; tick();
    end
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      n = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
      if (r < 2) begin
        idle_cycle();
      end else if (r < 4) begin
        s = ($urandom_range(0, 1) == 0) ? SEL_HI : SEL_LO;
        issue_wait(s, 1'($urandom_range(0, 3) != 0), n, $urandom_range(1, 4),
                   1'($urandom_range(0, 3) == 0));
      end else begin
        s = 3'($urandom);
        rnd_ops();
        issue(s, 1'($urandom_range(0, 3) != 0), n, 1'($urandom_range(0, 9) == 0),
              is_hilo(s) ? 1'b0 : 1'($urandom_range(0, 1)));
      end
    end

    for (int i = 0; i < 3; i++) idle_cycle();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
